// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared core sizing for the register file and its read ports
package reg_file_pkg;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one combinational read port with x0 zeroing and write forwarding
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int XLEN = reg_file_pkg::XLEN
) (
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  reg_write,
    input  logic [XLEN-1:0]       write_data,
    input  logic [XLEN-1:0]       reg_value,
    output logic [XLEN-1:0]       read_data
);
    logic fwd;
    assign fwd       = reg_write && (rd_addr == rs_addr);
    assign read_data = (!rst_n || rs_addr == '0) ? '0 : fwd ? write_data : reg_value;
endmodule

// File: rtl/reg_file.sv
// reg_file: NUM_REGS x XLEN register file, one write port, two forwarding read ports
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN     = reg_file_pkg::XLEN,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]       regf_write_data,
    input  logic                  reg_write,
    output logic [XLEN-1:0]       read_data1,
    output logic [XLEN-1:0]       read_data2
);
    logic [XLEN-1:0] regs [NUM_REGS];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_write && rd_addr != '0) begin
            regs[rd_addr] <= regf_write_data;
        end
    end
    reg_file_read_port #(.XLEN(XLEN)) u_port1 (
        .rst_n      (rst_n),
        .rs_addr    (rs1_addr),
        .rd_addr    (rd_addr),
        .reg_write  (reg_write),
        .write_data (regf_write_data),
        .reg_value  (regs[rs1_addr]),
        .read_data  (read_data1)
    );
    reg_file_read_port #(.XLEN(XLEN)) u_port2 (
        .rst_n      (rst_n),
        .rs_addr    (rs2_addr),
        .rd_addr    (rd_addr),
        .reg_write  (reg_write),
        .write_data (regf_write_data),
        .reg_value  (regs[rs2_addr]),
        .read_data  (read_data2)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
    import reg_file_pkg::*;
    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0]       regf_write_data;
    logic                  reg_write;
    logic [XLEN-1:0]       read_data1, read_data2;
    int errors = 0;
    int checks = 0;

    reg_file dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rd_addr         (rd_addr),
        .regf_write_data (regf_write_data),
        .reg_write       (reg_write),
        .read_data1      (read_data1),
        .read_data2      (read_data2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] d);
        reg_write = 1'b1; rd_addr = a; regf_write_data = d;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; reg_write = 1'b1; rd_addr = 5'd3; regf_write_data = 32'h1111_1111;
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        #2;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL rst_fwd1 got=%h exp=%h", read_data1, 32'h0); end
        checks++; if (read_data2 !== 32'h0) begin errors++; $display("FAIL rst_fwd2 got=%h exp=%h", read_data2, 32'h0); end
        tick();
        rst_n = 1'b1; reg_write = 1'b0;
        #1;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL rst_nowrite got=%h exp=%h", read_data1, 32'h0); end
        rs2_addr = 5'd31;
        #1;
        checks++; if (read_data2 !== 32'h0) begin errors++; $display("FAIL rst_x31 got=%h exp=%h", read_data2, 32'h0); end
    endtask

    task automatic test_write_read();
        write_reg(5'd1, 32'hA5A5_A5A5);
        rs1_addr = 5'd1;
        #1;
        checks++; if (read_data1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wr_x1 got=%h exp=%h", read_data1, 32'hA5A5_A5A5); end
        write_reg(5'd2, 32'h5A5A_5A5A);
        rs2_addr = 5'd2;
        #1;
        checks++; if (read_data2 !== 32'h5A5A_5A5A) begin errors++; $display("FAIL wr_x2 got=%h exp=%h", read_data2, 32'h5A5A_5A5A); end
        checks++; if (read_data1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL keep_x1 got=%h exp=%h", read_data1, 32'hA5A5_A5A5); end
    endtask

    task automatic test_x0();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL x0_p1 got=%h exp=%h", read_data1, 32'h0); end
        checks++; if (read_data2 !== 32'h0) begin errors++; $display("FAIL x0_p2 got=%h exp=%h", read_data2, 32'h0); end
        reg_write = 1'b1; rd_addr = 5'd0; regf_write_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL x0_nofwd got=%h exp=%h", read_data1, 32'h0); end
        tick();
        reg_write = 1'b0;
        #1;
        checks++; if (read_data2 !== 32'h0) begin errors++; $display("FAIL x0_write got=%h exp=%h", read_data2, 32'h0); end
    endtask

    task automatic test_forwarding();
        reg_write = 1'b1; rd_addr = 5'd5; regf_write_data = 32'h1234_5678;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        checks++; if (read_data1 !== 32'h1234_5678) begin errors++; $display("FAIL fwd_p1 got=%h exp=%h", read_data1, 32'h1234_5678); end
        checks++; if (read_data2 !== 32'h1234_5678) begin errors++; $display("FAIL fwd_p2 got=%h exp=%h", read_data2, 32'h1234_5678); end
        rs2_addr = 5'd1;
        #1;
        checks++; if (read_data2 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL fwd_other got=%h exp=%h", read_data2, 32'hA5A5_A5A5); end
        reg_write = 1'b0;
        #1;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL nofwd_we0 got=%h exp=%h", read_data1, 32'h0); end
        tick();
        #1;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL we0_nochange got=%h exp=%h", read_data1, 32'h0); end
        write_reg(5'd5, 32'h1234_5678);
        #1;
        checks++; if (read_data1 !== 32'h1234_5678) begin errors++; $display("FAIL x5_stored got=%h exp=%h", read_data1, 32'h1234_5678); end
        rd_addr = 5'd5; regf_write_data = 32'hDEAD_BEEF;
        tick();
        checks++; if (read_data1 !== 32'h1234_5678) begin errors++; $display("FAIL x5_held got=%h exp=%h", read_data1, 32'h1234_5678); end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] vals [4] = '{32'h0000_000A, 32'hCAFE_F00D, 32'h8000_0001, 32'h7FFF_FFFF};
        reg_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 5'(10 + i); regf_write_data = vals[i];
            tick();
        end
        rd_addr = 5'd31; regf_write_data = 32'h0F0F_0F0F;
        tick();
        rd_addr = 5'd31; regf_write_data = 32'hF0F0_F0F0;
        tick();
        reg_write = 1'b0;
        for (int i = 0; i < 4; i += 2) begin
            rs1_addr = 5'(10 + i); rs2_addr = 5'(11 + i);
            #1;
            checks++; if (read_data1 !== vals[i]) begin errors++; $display("FAIL b2b_p1_x%0d got=%h exp=%h", 10 + i, read_data1, vals[i]); end
            checks++; if (read_data2 !== vals[i+1]) begin errors++; $display("FAIL b2b_p2_x%0d got=%h exp=%h", 11 + i, read_data2, vals[i+1]); end
        end
        rs1_addr = 5'd31;
        #1;
        checks++; if (read_data1 !== 32'hF0F0_F0F0) begin errors++; $display("FAIL b2b_last_wins got=%h exp=%h", read_data1, 32'hF0F0_F0F0); end
    endtask

    task automatic test_async_reset();
        tick();
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        #1;
        checks++; if (read_data1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL pre_rst_x1 got=%h exp=%h", read_data1, 32'hA5A5_A5A5); end
        rst_n = 1'b0;
        #1;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL arst_x1 got=%h exp=%h", read_data1, 32'h0); end
        checks++; if (read_data2 !== 32'h0) begin errors++; $display("FAIL arst_x2 got=%h exp=%h", read_data2, 32'h0); end
        rst_n = 1'b1;
        #1;
        checks++; if (read_data1 !== 32'h0) begin errors++; $display("FAIL post_rst_x1 got=%h exp=%h", read_data1, 32'h0); end
        rs2_addr = 5'd31;
        #1;
        checks++; if (read_data2 !== 32'h0) begin errors++; $display("FAIL post_rst_x31 got=%h exp=%h", read_data2, 32'h0); end
        write_reg(5'd2, 32'h0BAD_CAFE);
        rs2_addr = 5'd2;
        #1;
        checks++; if (read_data2 !== 32'h0BAD_CAFE) begin errors++; $display("FAIL post_rst_wr got=%h exp=%h", read_data2, 32'h0BAD_CAFE); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_forwarding();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
